fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of every address and PC signal.
REQ-002 Parameter DATA_WIDTH, default 32, width of instruction words.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 Parameter DEPTH, default 2, instruction buffer entries (power of 2, >=2).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 imem_req  output  1  fetch request to instruction memory this cycle.
REQ-008 imem_addr  output  ADDR_WIDTH  word-aligned fetch address; valid when imem_req=1.
REQ-009 imem_rvalid  input  1  response valid; asserted exactly one cycle after each imem_req.
REQ-010 imem_rdata  input  DATA_WIDTH  instruction word; valid when imem_rvalid=1.
REQ-011 redirect_valid  input  1  branch/jump redirect from datapath.
REQ-012 redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as 0.
REQ-013 inst_valid  output  1  buffered instruction presented to decode.
REQ-014 inst  output  DATA_WIDTH  instruction word at buffer head.
REQ-015 inst_pc  output  ADDR_WIDTH  address of inst.
REQ-016 inst_ready  input  1  decode accepts; transfer occurs when inst_valid=1 and inst_ready=1.

Function
REQ-017 FSM states: IDLE, RUN, FLUSH; reset enters IDLE.
REQ-018 IDLE -> RUN unconditionally after one cycle; imem_req=0 in IDLE.
REQ-019 RUN: imem_req=1 iff (count + outstanding - pop) < DEPTH, where pop = inst_valid & inst_ready, outstanding = request issued previous cycle.
REQ-020 imem_addr = fetch_pc; fetch_pc increments by 4 on each issued request, wrapping modulo 2^ADDR_WIDTH.
REQ-021 Each request's address is carried alongside it; on imem_rvalid the pair {imem_rdata, address} is pushed to the buffer tail.
REQ-022 Buffer is FIFO; inst_valid = (count != 0); inst/inst_pc driven from head; pop on transfer.
REQ-023 Simultaneous push and pop at any count (including full or empty with head-of-line response) leaves count unchanged and preserves order; a response never bypasses the buffer.
REQ-024 Buffer never overflows; imem_rvalid arriving with buffer full and no pop is a protocol error flagged by assertion.
REQ-025 Steady state with inst_ready=1 continuously: one instruction per cycle, fetch-to-inst_valid latency 2 cycles from imem_req.
REQ-026 redirect_valid=1 in any state: next cycle state=FLUSH, fetch_pc=redirect_pc aligned, count=0; a transfer in the redirect cycle still completes.
REQ-027 FLUSH: imem_req=0; any imem_rvalid this cycle is discarded; unconditional return to RUN next cycle.
REQ-028 First request after redirect is issued in the cycle following FLUSH, at redirect_pc.
REQ-029 redirect_valid during FLUSH restarts FLUSH with the newer target (last redirect wins).
REQ-030 redirect_valid in IDLE overrides RESET_PC.
REQ-031 inst_valid, once high, stays high with inst/inst_pc stable until transfer or redirect.

Reset
REQ-032 On rst=1, asynchronously: state=IDLE, fetch_pc=RESET_PC, count=0, outstanding=0, imem_req=0, inst_valid=0.
REQ-033 inst, inst_pc, and buffer contents are don't-care while inst_valid=0.
REQ-034 Reset asserted mid-operation discards all buffered and in-flight instructions; a response arriving the cycle after deassert is ignored.

Verification
REQ-035 Reset release, inst_ready=1, memory returns addr-as-data -> imem_addr 0,4,8,... one per cycle from cycle 1; inst_pc 0 with inst_valid at cycle 3, then +4 each cycle.
REQ-036 inst_ready=0 for 10 cycles from start -> exactly DEPTH requests issued, imem_req stays 0 afterwards, inst_pc 0 held stable; on ready, 0,4 drain then fetch resumes at 8 without gap or duplicate.
REQ-037 redirect_valid with redirect_pc=0x103 while a response is in flight -> next cycle inst_valid=0, stale response dropped, next imem_addr=0x100, first inst_pc after redirect=0x100.
REQ-038 Back-to-back redirects 0x200 then 0x300 -> no instruction from 0x200 ever presented; first inst_pc=0x300.
REQ-039 fetch_pc=0xFFFF_FFFC -> next imem_addr=0x0000_0000; inst_pc sequence wraps identically.
REQ-040 rst pulsed while buffer full and request outstanding -> inst_valid=0 immediately, first post-reset inst_pc=RESET_PC, no pre-reset word observed.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues word-aligned requests to a fixed one-cycle-latency instruction memory.
// Responses are queued in a small FIFO that feeds decode over a valid/ready handshake.
// Redirects flush the FIFO and discard every in-flight response.
module fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic                  outstanding_q;

    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc_q   [DEPTH];

    logic                  push;
    logic                  pop;
    logic [OCC_W-1:0]      occupancy;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic                  unused_redirect_lsbs;

    // Low two bits of the redirect target are ignored; the target is word aligned.
    assign redirect_aligned     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A response is only accepted when it answers a request from the previous cycle
    // of an uninterrupted RUN stream; anything else is stale and dropped.
    assign pop  = inst_valid && inst_ready;
    assign push = imem_rvalid && outstanding_q && (state_q == S_RUN) && !redirect_valid;

    // Slots committed after this cycle: buffered words plus the word still in flight,
    // minus the word leaving now. A new request needs a guaranteed free slot.
    assign occupancy = OCC_W'(count_q) + OCC_W'(outstanding_q) - OCC_W'(pop);
    assign imem_req  = (state_q == S_RUN) && (occupancy < OCC_W'(DEPTH));
    assign imem_addr = fetch_pc_q;

    // Decode always sees the FIFO head; a response never bypasses the buffer.
    assign inst_valid = (count_q != '0);
    assign inst       = buf_data_q[head_q];
    assign inst_pc    = buf_pc_q[head_q];

    // Control FSM, fetch PC and in-flight request tracking.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            req_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
        end else begin
            // A request issued in the redirect cycle belongs to the old stream.
            outstanding_q <= imem_req && !redirect_valid;
            if (imem_req) begin
                req_addr_q <= fetch_pc_q;
            end
            if (redirect_valid) begin
                state_q    <= S_FLUSH;
                fetch_pc_q <= redirect_aligned;
            end else begin
                unique case (state_q)
                    S_IDLE:  state_q <= S_RUN;
                    S_RUN: begin
                        if (imem_req) begin
                            fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
                        end
                    end
                    S_FLUSH: state_q <= S_RUN;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    // NOTE: count_d gets a default before any branch so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO pointers and count; a redirect empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (redirect_valid) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage: each entry holds the instruction word and its fetch address.
    // NOTE: storage is not reset; its contents are meaningless while count_q is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[tail_q] <= imem_rdata;
            buf_pc_q[tail_q]   <= req_addr_q;
        end
    end

    // The request throttle must make a push into a full buffer without a pop impossible.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push && (count_q == CNT_W'(DEPTH)) && !pop)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit (default parameters).
// Memory model answers every request one cycle later with address ^ data_xor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        rvalid_q = 1'b0;
    logic [31:0] raddr_q  = '0;
    logic        inject_rvalid;
    logic [31:0] data_xor;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy;
        logic        rdir;
        logic [31:0] rpc;
        logic        inj;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vq[$];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory; inject_rvalid forces a spurious response.
    always @(posedge clk) begin
        rvalid_q <= imem_req;
        raddr_q  <= imem_addr;
    end
    assign imem_rvalid = rvalid_q | inject_rvalid;
    assign imem_rdata  = raddr_q ^ data_xor;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic rdir, input logic [31:0] rpc,
                                input logic inj, input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rdy = rdy; v.rdir = rdir; v.rpc = rpc; v.inj = inj;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        return v;
    endfunction

    // Apply one vector per cycle at the falling edge and compare outputs 1ns later.
    task automatic run_vq(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            inst_ready     = vq[i].rdy;
            redirect_valid = vq[i].rdir;
            redirect_pc    = vq[i].rpc;
            inject_rvalid  = vq[i].inj;
            #1;
            check($sformatf("%s c%0d imem_req", tag, i), 32'(imem_req), 32'(vq[i].req));
            if (vq[i].req)
                check($sformatf("%s c%0d imem_addr", tag, i), imem_addr, vq[i].addr);
            check($sformatf("%s c%0d inst_valid", tag, i), 32'(inst_valid), 32'(vq[i].vld));
            if (vq[i].vld) begin
                check($sformatf("%s c%0d inst_pc", tag, i), inst_pc, vq[i].pc);
                check($sformatf("%s c%0d inst", tag, i), inst, vq[i].pc ^ data_xor);
            end
            @(negedge clk);
        end
        vq.delete();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        inject_rvalid  = 1'b0;
    endtask

    // Reset for two cycles; returns at the falling edge where rst drops (cycle 0).
    task automatic do_reset(input string tag);
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inject_rvalid  = 1'b0;
        #1;
        check({tag, " reset imem_req"}, 32'(imem_req), 32'd0);
        check({tag, " reset inst_valid"}, 32'(inst_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        data_xor = '0;

        // Steady streaming, addr-as-data: req from cycle 1, first inst at cycle 3.
        do_reset("stream");
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 10; c++)
            vq.push_back(mk(1, 0, 0, 0, 1, 32'(4 * (c - 1)), c >= 3, 32'(4 * (c - 3))));
        run_vq("stream");

        data_xor = 32'hDEAD_0000;

        // Decode stalled 10 cycles: exactly two requests, head held, then gapless drain.
        do_reset("stall");
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 32'h0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 32'h4, 0, 0));
        for (int c = 3; c <= 9; c++)
            vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0));
        for (int c = 10; c <= 14; c++)
            vq.push_back(mk(1, 0, 0, 0, 1, 32'(8 + 4 * (c - 10)), 1, 32'(4 * (c - 10))));
        run_vq("stall");

        // Redirect to 0x103 with a transfer and a response in flight.
        do_reset("redir");
        vq.push_back(mk(1, 0, 0,          0, 0, 0,         0, 0));
        vq.push_back(mk(1, 0, 0,          0, 1, 32'h0,     0, 0));
        vq.push_back(mk(1, 0, 0,          0, 1, 32'h4,     0, 0));
        vq.push_back(mk(1, 1, 32'h103,    0, 1, 32'h8,     1, 32'h0));
        vq.push_back(mk(1, 0, 0,          0, 0, 0,         0, 0));
        vq.push_back(mk(1, 0, 0,          0, 1, 32'h100,   0, 0));
        vq.push_back(mk(1, 0, 0,          0, 1, 32'h104,   0, 0));
        vq.push_back(mk(1, 0, 0,          0, 1, 32'h108,   1, 32'h100));
        vq.push_back(mk(1, 0, 0,          0, 1, 32'h10C,   1, 32'h104));
        run_vq("redir");

        // Redirect in IDLE to 0x200, then again during FLUSH to 0x300: last one wins.
        do_reset("b2b");
        vq.push_back(mk(1, 1, 32'h200, 0, 0, 0,       0, 0));
        vq.push_back(mk(1, 1, 32'h300, 0, 0, 0,       0, 0));
        vq.push_back(mk(1, 0, 0,       0, 0, 0,       0, 0));
        vq.push_back(mk(1, 0, 0,       0, 1, 32'h300, 0, 0));
        vq.push_back(mk(1, 0, 0,       0, 1, 32'h304, 0, 0));
        vq.push_back(mk(1, 0, 0,       0, 1, 32'h308, 1, 32'h300));
        vq.push_back(mk(1, 0, 0,       0, 1, 32'h30C, 1, 32'h304));
        run_vq("b2b");

        // Address wrap past 0xFFFF_FFFC.
        do_reset("wrap");
        vq.push_back(mk(1, 1, 32'hFFFF_FFF8, 0, 0, 0,            0, 0));
        vq.push_back(mk(1, 0, 0,             0, 0, 0,            0, 0));
        vq.push_back(mk(1, 0, 0,             0, 1, 32'hFFFF_FFF8, 0, 0));
        vq.push_back(mk(1, 0, 0,             0, 1, 32'hFFFF_FFFC, 0, 0));
        vq.push_back(mk(1, 0, 0,             0, 1, 32'h0,        1, 32'hFFFF_FFF8));
        vq.push_back(mk(1, 0, 0,             0, 1, 32'h4,        1, 32'hFFFF_FFFC));
        vq.push_back(mk(1, 0, 0,             0, 1, 32'h8,        1, 32'h0));
        vq.push_back(mk(1, 0, 0,             0, 1, 32'hC,        1, 32'h4));
        run_vq("wrap");

        // Reset pulsed with a word buffered and a response in flight.
        do_reset("mrst");
        vq.push_back(mk(1, 0, 0, 0, 0, 0,     0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1, 32'h0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1, 32'h4, 0, 0));
        run_vq("mrst");
        inst_ready = 1'b1;
        #1;
        check("mrst pre inst_valid", 32'(inst_valid), 32'd1);
        check("mrst pre inst_pc", inst_pc, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check("mrst async inst_valid", 32'(inst_valid), 32'd0);
        check("mrst async imem_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Spurious responses right after deassert must be ignored.
        vq.push_back(mk(1, 0, 0, 1, 0, 0,     0, 0));
        vq.push_back(mk(1, 0, 0, 1, 1, 32'h0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1, 32'h4, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1, 32'h8, 1, 32'h0));
        vq.push_back(mk(1, 0, 0, 0, 1, 32'hC, 1, 32'h4));
        run_vq("mrst post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
